// File: rtl/booth_r4_seq_mult_if.sv
// booth_r4_seq_mult_if -- request/response bundle for the radix-4 Booth
// sequential multiplier.
//   start   : request, only looked at while the multiplier is not busy
//   a, b    : multiplicand / multiplier, captured when start is accepted
//   busy    : a multiplication is in flight
//   done    : one-cycle pulse, product is valid
//   product : 2*WIDTH result, held until the next accepted start
// master = requester, slave = multiplier.
interface booth_r4_seq_mult_if #(
  parameter int WIDTH = 8
) ();
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input  busy, done, product);
  modport slave  (input  start, a, b, output busy, done, product);
endinterface

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult -- sequential radix-4 Booth multiplier, one Booth digit
// retired per RUN cycle.
//   clk   : single clock, rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : booth_r4_seq_mult_if.slave (start, a, b in; busy, done, product out)
// Build option: define BOOTH_SIGNED_EN for two's complement operands
// (NDIG = WIDTH/2); otherwise operands are unsigned, b is zero-extended by
// two bits and NDIG = WIDTH/2+1.
// WIDTH must be even and >= 4.
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  booth_r4_seq_mult_if.slave bus
);
`ifdef BOOTH_SIGNED_EN
  localparam int NDIG = WIDTH / 2;
`else
  localparam int NDIG = WIDTH / 2 + 1;
`endif
  localparam int AW = WIDTH + 2;       // accumulator: room for +-2A
  localparam int MW = 2 * NDIG;        // multiplier shift register
  localparam int PH = 2 * WIDTH - MW;  // accumulator bits that land in product
  localparam int CW = $clog2(NDIG);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_load, w_step, w_last;
  logic [AW-1:0]      r_acc, r_a;
  logic [MW-1:0]      r_mul;
  logic               r_bm1;            // b[2i-1] of the current digit
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;

  logic [AW-1:0]      w_a_ext;
  logic [MW-1:0]      w_b_ext;
  logic [2:0]         w_dig;
  logic               w_zero, w_two, w_neg;
  logic [AW-1:0]      w_mult, w_addend, w_sum, w_acc_nxt;
  logic [MW-1:0]      w_mul_nxt;

`ifdef BOOTH_SIGNED_EN
  assign w_a_ext = {{2{bus.a[WIDTH-1]}}, bus.a};
  assign w_b_ext = bus.b;
`else
  assign w_a_ext = {2'b00, bus.a};
  assign w_b_ext = {2'b00, bus.b};
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state / datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_load      = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(NDIG - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Booth digit decode from (b[2i+1], b[2i], b[2i-1])
  assign w_dig = {r_mul[1:0], r_bm1};
  always_comb begin
    w_zero = 1'b0;
    w_two  = 1'b0;
    w_neg  = 1'b0;
    case (w_dig)
      3'b000, 3'b111: w_zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         w_two  = 1'b1;
      3'b100: begin   w_two  = 1'b1; w_neg = 1'b1; end
      default:        w_neg  = 1'b1;   // 101, 110
    endcase
  end

  // Negative multiples: invert here, the +1 rides in as carry on the add.
  always_comb begin
    w_mult = '0;
    if (!w_zero) w_mult = w_two ? {r_a[AW-2:0], 1'b0} : r_a;
    w_addend  = w_neg ? ~w_mult : w_mult;
    w_sum     = r_acc + w_addend + AW'(w_neg);
    // {acc, mul} is one long register shifted arithmetically by 2
    w_acc_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    w_mul_nxt = {w_sum[1:0], r_mul[MW-1:2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_mul  <= '0;
      r_bm1  <= 1'b0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else if (w_load) begin
      r_acc  <= '0;
      r_a    <= w_a_ext;
      r_mul  <= w_b_ext;
      r_bm1  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_acc  <= w_acc_nxt;
      r_mul  <= w_mul_nxt;
      r_bm1  <= r_mul[1];
      r_cnt  <= r_cnt + 1'b1;
      // After the last digit the low 2*WIDTH bits of {acc, mul} are A*B.
      if (w_last) r_prod <= {w_acc_nxt[PH-1:0], w_mul_nxt};
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_prod;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult (WIDTH=8). Build with or
// without BOOTH_SIGNED_EN; expectations follow the selected operand format.
module tb_booth_r4_seq_mult;
  localparam int W = 8;
`ifdef BOOTH_SIGNED_EN
  localparam int NDIG = W / 2;
`else
  localparam int NDIG = W / 2 + 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;

  booth_r4_seq_mult_if #(.WIDTH(W)) bif ();
  booth_r4_seq_mult #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic product in the selected format.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
`ifdef BOOTH_SIGNED_EN
    p = longint'($signed(x)) * longint'($signed(y));
`else
    p = longint'({1'b0, x}) * longint'({1'b0, y});
`endif
    return p[2*W-1:0];
  endfunction

  // Issue one operation from idle; optionally scribble on inputs while busy.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit noise,
                       output logic [2*W-1:0] p, output int lat);
    @(negedge clk);
    bif.start = 1'b1; bif.a = x; bif.b = y;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (bif.done !== 1'b1 && lat < 40) begin
      if (noise) begin
        bif.start = 1'($urandom_range(0, 1));
        bif.a = W'($urandom); bif.b = W'($urandom);
      end else bif.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bif.start = 1'b0;
    p = bif.product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.start = 1'b1; bif.a = 8'h55; bif.b = 8'h33;
    repeat (3) @(negedge clk);
    nvec++; if (bif.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", bif.busy); end
    nvec++; if (bif.done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", bif.done); end
    nvec++; if (bif.product !== 16'h0000) begin nerr++; $display("FAIL reset_product: got %h expected 0000", bif.product); end
    bif.start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0]   da [5];
    logic [W-1:0]   db [5];
    logic [2*W-1:0] dp [5];
    logic [2*W-1:0] p;
    int lat;
`ifdef BOOTH_SIGNED_EN
    da = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h7F};
    db = '{8'h80, 8'h80, 8'hA5, 8'hFF, 8'h7F};
    dp = '{16'h4000, 16'hC080, 16'h0000, 16'h0001, 16'h3F01};
`else
    da = '{8'hFF, 8'h80, 8'h7F, 8'h00, 8'h01};
    db = '{8'hFF, 8'h80, 8'h80, 8'hA5, 8'hFF};
    dp = '{16'hFE01, 16'h4000, 16'h3F80, 16'h0000, 16'h00FF};
`endif
    for (int i = 0; i < 5; i++) begin
      do_op(da[i], db[i], 1'b1, p, lat);
      nvec++; if (lat != NDIG) begin nerr++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NDIG); end
      nvec++; if (p !== dp[i]) begin nerr++; $display("FAIL directed_product[%0d]: got %h expected %h", i, p, dp[i]); end
      @(negedge clk);
      nvec++; if (bif.done !== 1'b0 || bif.busy !== 1'b0 || bif.product !== dp[i]) begin
        nerr++; $display("FAIL directed_hold[%0d]: got done=%b busy=%b product=%h expected 0 0 %h",
                         i, bif.done, bif.busy, bif.product, dp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p;
    int lat, gap;
    do_op(8'h0C, 8'h0B, 1'b1, p, lat);
    nvec++; if (p !== 16'h0084) begin nerr++; $display("FAIL b2b_first: got %h expected 0084", p); end
    // still in the DONE cycle: hold start high with new operands
    bif.start = 1'b1; bif.a = 8'h03; bif.b = 8'h05;
    @(negedge clk);
    gap = 1;
    nvec++; if (bif.busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy: got %b expected 1", bif.busy); end
    while (bif.done !== 1'b1 && gap < 40) begin
      bif.start = 1'($urandom_range(0, 1));
      bif.a = W'($urandom); bif.b = W'($urandom);
      @(negedge clk);
      gap++;
    end
    bif.start = 1'b0;
    nvec++; if (gap != NDIG + 1) begin nerr++; $display("FAIL b2b_gap: got %0d expected %0d", gap, NDIG + 1); end
    nvec++; if (bif.product !== 16'h000F) begin nerr++; $display("FAIL b2b_product: got %h expected 000F", bif.product); end
  endtask

  task automatic test_reset_midrun();
    logic [2*W-1:0] p;
    int lat;
    bit seen;
    @(negedge clk);
    bif.start = 1'b1; bif.a = 8'h5A; bif.b = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bif.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (bif.busy !== 1'b0) begin nerr++; $display("FAIL midrun_busy: got %b expected 0", bif.busy); end
    nvec++; if (bif.done !== 1'b0) begin nerr++; $display("FAIL midrun_done: got %b expected 0", bif.done); end
    nvec++; if (bif.product !== 16'h0000) begin nerr++; $display("FAIL midrun_product: got %h expected 0000", bif.product); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < NDIG + 3; k++) begin
      @(negedge clk);
      if (bif.done !== 1'b0) seen = 1'b1;
    end
    nvec++; if (seen) begin nerr++; $display("FAIL midrun_no_done: got done pulse expected none"); end
    do_op(8'h06, 8'h07, 1'b0, p, lat);
    nvec++; if (lat != NDIG) begin nerr++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, NDIG); end
    nvec++; if (p !== 16'h002A) begin nerr++; $display("FAIL post_reset_product: got %h expected 002A", p); end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0]   x, y;
    logic [2*W-1:0] expv;
    int lat;
    x = W'($urandom); y = W'($urandom);
    @(negedge clk);
    bif.start = 1'b1; bif.a = x; bif.b = y;
    for (int i = 0; i < n; i++) begin
      expv = ref_mul(x, y);
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (bif.done !== 1'b1 && lat < 40) begin
        bif.start = 1'($urandom_range(0, 1));
        bif.a = W'($urandom); bif.b = W'($urandom);
        @(negedge clk);
        lat++;
      end
      nvec++;
      if (lat != NDIG || bif.product !== expv) begin
        nerr++;
        $display("FAIL random[%0d] a=%h b=%h: got product=%h latency=%0d expected product=%h latency=%0d",
                 i, x, y, bif.product, lat, expv, NDIG);
      end
      if (lat >= 40) begin bif.start = 1'b0; return; end
      x = W'($urandom); y = W'($urandom);
      if (i == n - 1) begin
        bif.start = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bif.start = 1'b0;
        @(negedge clk);
        nvec++;
        if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.product !== expv) begin
          nerr++;
          $display("FAIL random_idle[%0d]: got busy=%b done=%b product=%h expected 0 0 %h",
                   i, bif.busy, bif.done, bif.product, expv);
        end
        bif.start = 1'b1; bif.a = x; bif.b = y;
      end else begin
        bif.start = 1'b1; bif.a = x; bif.b = y;
      end
    end
  endtask

  initial begin
    bif.start = 1'b0; bif.a = '0; bif.b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midrun();
    test_random(10000);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/booth_r4_seq_mult.md
BOOTH_R4_SEQ_MULT -- requirements
Module: booth_r4_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled on rising clk edge only while busy=0.
REQ-005 a  input  WIDTH  multiplicand; captured when start is accepted.
REQ-006 b  input  WIDTH  multiplier; captured when start is accepted.
REQ-007 busy  output  1  high while a multiplication is in progress (RUN state).
REQ-008 done  output  1  single-cycle pulse marking product valid.
REQ-009 product  output  2*WIDTH  result; held stable from done until the next accepted start.

Function
REQ-010 The block SHALL implement a radix-4 Booth multiplier that retires one Booth digit per RUN cycle.
REQ-011 Digit i SHALL be taken from bits (b[2i+1], b[2i], b[2i-1]), with b[-1]=0.
REQ-012 Digit encoding: 000,111->0; 001,010->+A; 011->+2A; 100->-2A; 101,110->-A.
REQ-013 Negative digits SHALL be formed as one's complement of the selected multiple plus carry-in 1 in the same cycle.
REQ-014 The accumulator SHALL be WIDTH+2 bits wide with sign extension, so +-2A never overflows.
REQ-015 The accumulator and multiplier SHALL shift right arithmetically by 2 each RUN cycle.
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE->RUN on start=1, capturing a and b, clearing the accumulator, and setting the digit counter to 0.
REQ-018 RUN->DONE when the last digit has been retired (counter = NDIG-1); otherwise the counter increments.
REQ-019 DONE->RUN if start=1, which is a back-to-back accept; otherwise DONE->IDLE.
REQ-020 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-021 Latency: the start accepted at edge t0 SHALL produce done=1 and a valid product in the cycle following edge t0+NDIG.
REQ-022 start while busy=1 SHALL be ignored; captured operands SHALL be unaffected by input changes during RUN.
REQ-023 product SHALL update only on the RUN->DONE transition.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, product=0, accumulator=0, counter=0, regardless of the clock.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-027 Macro BOOTH_SIGNED_EN SHALL select the operand format.
REQ-028 With BOOTH_SIGNED_EN defined: a and b are two's complement, NDIG = WIDTH/2, and product is a signed 2*WIDTH result.
REQ-029 Without BOOTH_SIGNED_EN: a and b are unsigned.
REQ-030 Without BOOTH_SIGNED_EN: b is zero-extended by 2 bits, a is zero-extended into the accumulator, NDIG = WIDTH/2+1, and product is unsigned 2*WIDTH.

Verification (WIDTH=8)
REQ-031 Signed: a=0x80, b=0x80, start one cycle -> done after 5 edges, product=0x4000.
REQ-032 Signed: a=0x7F, b=0x80 -> product=0xC080; a=0x00, b=0xA5 -> product=0x0000.
REQ-033 Unsigned build: a=0xFF, b=0xFF -> done after 6 edges, product=0xFE01.
REQ-034 Back-to-back: start held high across DONE with new a=0x03, b=0x05 -> second done exactly NDIG+1 cycles after the first, product=0x000F; operand changes during RUN have no effect.
REQ-035 Reset: rst_n pulsed low in the 2nd RUN cycle -> busy=0, done=0, product=0 asynchronously, and no done pulse follows.
REQ-036 Random: 10000 random operand pairs in each build checked against a reference product, with start asserted while busy=1 ignored.
